// File: rtl/key_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// key_buffer_ctrl
//
// Sequencer for the keypoint FIFO between the FAST/orientation stage and the
// BRIEF descriptor stage. It tracks the raster position of the BRIEF window and
// generates the insert (o_flag) and pop (o_hit) strobes for the keypoint shift
// buffer. It also keeps the occupancy count and flushes leftover keypoints at
// the end of each frame.
//
// Handshake semantics (all strobes are single-cycle and registered):
//   i_pix_valid  : one raster pixel is accepted in this cycle. The window
//                  position (x_cnt, y_cnt) refers to that pixel.
//   i_kp_valid   : a keypoint is offered in this cycle. It is either inserted
//                  (o_flag high in the next cycle) or dropped. There is no
//                  back-pressure.
//   o_hit        : the buffer pops its head in this cycle. o_desc_start marks
//                  pops whose patch is complete; drain pops do not set it.
//   o_flag/o_hit : may both be high in the same cycle. The buffer then shifts
//                  and inserts, so the occupancy is unchanged.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_frame_start      pulse; the first pixel of a frame follows
//   i_pix_valid        raster pixel strobe
//   i_kp_valid         new keypoint strobe
//   i_head_x/i_head_y  coordinates of the oldest buffered keypoint
//   o_flag             buffer insert strobe
//   o_hit              buffer pop strobe
//   o_desc_start       start a descriptor for the popped head
//   o_count            buffer occupancy
//   o_full/o_empty     occupancy == DEPTH / == 0
//   o_frame_done       pulse when the end-of-frame drain has finished
//   o_seq_err          sticky; i_frame_start was seen outside IDLE
//   o_drop_cnt         saturating count of dropped keypoints (stats build)
//   o_peak_occ         peak occupancy in the current frame (stats build)
//
// Optional statistics: define KEY_BUFFER_CTRL_STATS_EN to build the drop and
// peak counters. Without it, o_drop_cnt and o_peak_occ are tied to zero.
// ---------------------------------------------------------------------------
module key_buffer_ctrl #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int DELAY_ROWS = 15,
  parameter int DELAY_COLS = 15,
  parameter int DEPTH      = 60,
  parameter int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_pix_valid,
  input  logic             i_kp_valid,
  input  logic [9:0]       i_head_x,
  input  logic [9:0]       i_head_y,
  output logic             o_flag,
  output logic             o_hit,
  output logic             o_desc_start,
  output logic [OCC_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_frame_done,
  output logic             o_seq_err,
  output logic [15:0]      o_drop_cnt,
  output logic [OCC_W-1:0] o_peak_occ
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [9:0]       X_LAST    = 10'(IMG_W - 1);
  localparam logic [9:0]       Y_LAST    = 10'(IMG_H - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [1:0] state, state_next;
  logic [9:0] x_cnt, x_next;
  logic [9:0] y_cnt, y_next;
  // Guard equals "o_hit is high in this cycle". While the buffer is shifting,
  // the head inputs are stale, so no pop decision may use them.
  logic       guard;

  logic [10:0]      tx, ty, x_ext, y_ext;
  logic             reached;
  logic             has_kp;
  logic             hit_next;
  logic             desc_next;
  logic             flag_next;
  logic             done_next;
  logic             drop;
  logic             clear_frame;
  logic [OCC_W-1:0] count_next;

  // Hit target. The 11-bit sums cannot wrap. A head whose target lies below
  // the last row never matches in RUN and is flushed during DRAIN.
  always_comb begin
    tx      = {1'b0, i_head_x} + 11'(DELAY_COLS);
    ty      = {1'b0, i_head_y} + 11'(DELAY_ROWS);
    x_ext   = {1'b0, x_cnt};
    y_ext   = {1'b0, y_cnt};
    reached = (y_ext > ty) || ((y_ext == ty) && (x_ext >= tx));
  end

  always_comb begin
    has_kp      = (o_count != '0);
    clear_frame = (state == IDLE) && i_frame_start;
    hit_next    = 1'b0;
    desc_next   = 1'b0;
    done_next   = 1'b0;
    case (state)
      RUN: begin
        hit_next  = has_kp && i_pix_valid && !guard && reached;
        desc_next = hit_next;
      end
      DRAIN: begin
        hit_next  = has_kp && !guard;
        done_next = !has_kp;
      end
      default: ;
    endcase
    // A pop issued in the same cycle frees a slot for the insert.
    flag_next = i_kp_valid && (state == RUN) &&
                ((o_count < DEPTH_OCC) || hit_next);
    drop      = i_kp_valid && !flag_next;
  end

  always_comb begin
    count_next = o_count;
    if (clear_frame) begin
      count_next = '0;
    end else if (flag_next && !hit_next) begin
      count_next = o_count + OCC_W'(1);
    end else if (hit_next && !flag_next) begin
      count_next = o_count - OCC_W'(1);
    end
  end

  // Raster position of the BRIEF window and the frame state machine.
  always_comb begin
    state_next = state;
    x_next     = x_cnt;
    y_next     = y_cnt;
    case (state)
      IDLE: begin
        if (i_frame_start) begin
          state_next = RUN;
          x_next     = '0;
          y_next     = '0;
        end
      end
      RUN: begin
        if (i_pix_valid) begin
          if (x_cnt == X_LAST) begin
            x_next = '0;
            if (y_cnt == Y_LAST) begin
              y_next     = '0;
              state_next = DRAIN;
            end else begin
              y_next = y_cnt + 10'd1;
            end
          end else begin
            x_next = x_cnt + 10'd1;
          end
        end
      end
      DRAIN: begin
        if (!has_kp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      guard        <= 1'b0;
      o_flag       <= 1'b0;
      o_hit        <= 1'b0;
      o_desc_start <= 1'b0;
      o_count      <= '0;
      o_full       <= 1'b0;
      o_empty      <= 1'b0;
      o_frame_done <= 1'b0;
      o_seq_err    <= 1'b0;
    end else begin
      state        <= state_next;
      x_cnt        <= x_next;
      y_cnt        <= y_next;
      guard        <= hit_next;
      o_flag       <= flag_next;
      o_hit        <= hit_next;
      o_desc_start <= desc_next;
      o_count      <= count_next;
      o_full       <= (count_next == DEPTH_OCC);
      o_empty      <= (count_next == '0);
      o_frame_done <= done_next;
      if (i_frame_start && (state != IDLE)) o_seq_err <= 1'b1;
    end
  end

`ifdef KEY_BUFFER_CTRL_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= '0;
      o_peak_occ <= '0;
    end else begin
      if (drop && (o_drop_cnt != 16'hffff)) o_drop_cnt <= o_drop_cnt + 16'd1;
      if (clear_frame) begin
        o_peak_occ <= '0;
      end else if (count_next > o_peak_occ) begin
        o_peak_occ <= count_next;
      end
    end
  end
`else
  assign o_drop_cnt = '0;
  assign o_peak_occ = '0;
  logic unused_stats;
  assign unused_stats = drop;
`endif

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_buffer_ctrl
//
// Directed bench for key_buffer_ctrl with IMG 16x16, delays 3 columns and
// 2 rows, and DEPTH 4. Stimulus pushes the hand-computed output events
// {cycle, done, flag, hit, desc, count, full} into exp_q. A monitor pops one
// entry for every cycle in which o_flag, o_hit or o_frame_done is high.
// Static state (reset, full, seq_err, stats) is compared directly.
// ---------------------------------------------------------------------------
module tb_key_buffer_ctrl;
  localparam int OCC_W = 3;
  localparam int EW    = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start, pix_valid, kp_valid;
  logic [9:0]       head_x, head_y;
  logic             flag, hit, desc_start, full, empty, frame_done, seq_err;
  logic [OCC_W-1:0] count, peak_occ;
  logic [15:0]      drop_cnt;

  key_buffer_ctrl #(
    .IMG_W(16), .IMG_H(16), .DELAY_ROWS(2), .DELAY_COLS(3), .DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .i_pix_valid(pix_valid), .i_kp_valid(kp_valid),
    .i_head_x(head_x), .i_head_y(head_y),
    .o_flag(flag), .o_hit(hit), .o_desc_start(desc_start), .o_count(count),
    .o_full(full), .o_empty(empty), .o_frame_done(frame_done),
    .o_seq_err(seq_err), .o_drop_cnt(drop_cnt), .o_peak_occ(peak_occ)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [9:0] nxt_hx = '0;
  logic [9:0] nxt_hy = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected event d cycles after the current drive slot.
  task automatic expect_ev(input int d, input bit done, input bit f, input bit h,
                           input bit ds, input logic [OCC_W-1:0] c, input bit fl);
    int t;
    t = cyc + d;
    exp_q.push_back({t[15:0], done, f, h, ds, c, fl});
  endtask

  task automatic monitor_loop();
    logic [EW-1:0] act;
    forever begin
      @(negedge clk);
      if (rst_n && (flag || hit || frame_done)) begin
        act = {cyc[15:0], frame_done, flag, hit, desc_start, count, full};
        if (exp_q.size() == 0) chk("unexpected_event", act, 32'h0);
        else chk("event", act, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit pv, input bit kp, input bit fs);
    @(posedge clk);
    #1;
    pix_valid   = pv;
    kp_valid    = kp;
    frame_start = fs;
    head_x      = nxt_hx;
    head_y      = nxt_hy;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic set_head(input int x, input int y);
    nxt_hx = 10'(x);
    nxt_hy = 10'(y);
  endtask

  // Drain of n entries after the last pixel: pops on alternate cycles, then done.
  task automatic expect_drain(input int n);
    for (int i = 0; i < n; i++) expect_ev(2 + 2 * i, 0, 0, 1, 0, 3'(n - 1 - i), 0);
    expect_ev(n == 0 ? 2 : 2 * n + 1, 1, 0, 0, 0, 3'd0, 0);
  endtask

  // One full frame for scenario sc.
  task automatic run_frame(input int sc);
    bit kp;
    case (sc)
      1, 2: set_head(5, 4);
      default: set_head(0, 15);
    endcase
    step(1'b0, 1'b0, 1'b1);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        kp = 1'b0;
        case (sc)
          1: kp = (x == 0 && y == 0);
          2: begin
            kp = (y == 0 && x < 2);
            if (x == 9 && y == 6) set_head(6, 4);
          end
          3: kp = (y == 0 && x < 5);
          4: begin
            kp = (y == 0 && x < 4) || (x == 4 && y == 2);
            if (x == 5 && y == 0) set_head(1, 0);
            if (x == 5 && y == 2) set_head(0, 15);
          end
          default: kp = (y == 15 && x < 3);
        endcase
        step(1'b1, kp, 1'b0);
        case (sc)
          1: begin
            if (x == 0 && y == 0) expect_ev(1, 0, 1, 0, 0, 3'd1, 0);
            if (x == 8 && y == 6) expect_ev(1, 0, 0, 1, 1, 3'd0, 0);
          end
          2: begin
            if (x < 2 && y == 0) expect_ev(1, 0, 1, 0, 0, 3'(x + 1), 0);
            if (x == 8 && y == 6) expect_ev(1, 0, 0, 1, 1, 3'd1, 0);
            if (x == 10 && y == 6) expect_ev(1, 0, 0, 1, 1, 3'd0, 0);
          end
          3, 4: begin
            if (x < 4 && y == 0) expect_ev(1, 0, 1, 0, 0, 3'(x + 1), x == 3);
            if (sc == 4 && x == 4 && y == 2) expect_ev(1, 0, 1, 1, 1, 3'd4, 1);
            if (x == 10 && y == sc - 3 + (sc == 4 ? 1 : 0)) begin
              chk("full_flag", full, 1);
              chk("full_count", count, 4);
`ifdef KEY_BUFFER_CTRL_STATS_EN
              chk("drop_cnt", drop_cnt, 1);
              chk("peak_occ", peak_occ, 4);
`else
              chk("drop_cnt_tied", drop_cnt, 0);
              chk("peak_occ_tied", peak_occ, 0);
`endif
            end
          end
          default: if (y == 15 && x < 3) expect_ev(1, 0, 1, 0, 0, 3'(x + 1), 0);
        endcase
        if (x == 15 && y == 15) expect_drain(sc == 5 ? 3 : (sc >= 3 ? 4 : 0));
      end
    end
    idle(2);
    wait_empty();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    kp_valid = 1'b0;
    head_x = '0;
    head_y = '0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_flag", flag, 0);
    chk("rst_hit", hit, 0);
    chk("rst_desc", desc_start, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_peak", peak_occ, 0);
    rst_n = 1'b1;

    for (int sc = 1; sc <= 5; sc++) run_frame(sc);

    // Back in IDLE: a keypoint is dropped silently.
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    chk("idle_seq_err", seq_err, 0);
    chk("idle_count", count, 0);
`ifdef KEY_BUFFER_CTRL_STATS_EN
    chk("idle_drop_cnt", drop_cnt, 2);
`endif

    // Frame start while running, then asynchronous reset in the middle of the frame.
    set_head(5, 4);
    step(1'b0, 1'b0, 1'b1);
`ifdef KEY_BUFFER_CTRL_STATS_EN
    @(negedge clk);
    chk("peak_cleared", peak_occ, 0);
`endif
    for (int p = 0; p < 7 * 16; p++) begin
      int x, y;
      x = p % 16;
      y = p / 16;
      if (x == 9 && y == 6) set_head(0, 15);
      step(1'b1, (p == 0) || (x == 9 && y == 6), 1'b0);
      if (p == 0) expect_ev(1, 0, 1, 0, 0, 3'd1, 0);
      if (x == 8 && y == 6) expect_ev(1, 0, 0, 1, 1, 3'd0, 0);
      if (x == 9 && y == 6) expect_ev(1, 0, 1, 0, 0, 3'd1, 0);
      if (p == 1) begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("seq_err_set", seq_err, 1);
      end
    end
    idle(2);
    wait_empty();
    @(negedge clk);
    chk("pre_rst_count", count, 1);
    chk("pre_rst_seq_err", seq_err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_seq_err", seq_err, 0);
    chk("arst_flag", flag, 0);
    chk("arst_hit", hit, 0);
    chk("arst_empty", empty, 0);
    chk("arst_full", full, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    @(negedge clk);
    chk("post_rst_seq_err", seq_err, 0);
    chk("post_rst_empty", empty, 1);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_buffer_ctrl.md
Name: key_buffer_ctrl

Overview:
- Sequences the keypoint FIFO that sits between the FAST/orientation stage and the BRIEF descriptor stage.
- Generates the insert (flag) and pop (hit) strobes for the keypoint shift buffer.
- Tracks the raster position of the BRIEF window so each buffered keypoint is popped once its full patch has streamed in.
- Keeps the authoritative occupancy count and flushes leftover keypoints at end of frame.

Parameters:
- IMG_W, 640, pixels per row
- IMG_H, 480, rows per frame
- DELAY_ROWS, 15, rows after the keypoint row before its patch is complete
- DELAY_COLS, 15, columns after the keypoint column before its patch is complete
- DEPTH, 60, keypoint buffer depth
- OCC_W, $clog2(DEPTH+1), occupancy width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_frame_start  in  1  one-cycle pulse, first pixel of a frame follows
- i_pix_valid  in  1  one pixel of the raster stream accepted this cycle
- i_kp_valid  in  1  new keypoint presented this cycle
- i_head_x  in  10  x of the oldest buffered keypoint (buffer output)
- i_head_y  in  10  y of the oldest buffered keypoint
- o_flag  out  1  buffer insert strobe
- o_hit  out  1  buffer pop strobe
- o_desc_start  out  1  BRIEF: compute descriptor for the popped head
- o_count  out  OCC_W  buffer occupancy
- o_full  out  1  o_count==DEPTH
- o_empty  out  1  o_count==0
- o_frame_done  out  1  one-cycle pulse, drain complete
- o_seq_err  out  1  sticky, i_frame_start received outside IDLE
- o_drop_cnt  out  16  keypoints dropped (optional feature)
- o_peak_occ  out  OCC_W  max occupancy this frame (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; x_cnt=0, y_cnt=0.
- FSM states:
  - IDLE: on i_frame_start go to RUN and clear x/y counters, occupancy, peak and the guard.
  - RUN: on i_pix_valid, x_cnt increments. At IMG_W-1 it wraps to 0 and y_cnt increments. A valid pixel at (IMG_W-1, IMG_H-1) goes to DRAIN.
  - DRAIN: o_hit=1 with o_desc_start=0 on every cycle with occupancy>0, except a cycle where the guard is set. When occupancy reaches 0, pulse o_frame_done and go to IDLE.
- Hit target: tx=i_head_x+DELAY_COLS, ty=i_head_y+DELAY_ROWS, computed in 11 bits with no truncation.
- Hit in RUN, all registered:
  - Condition: !o_empty && i_pix_valid && guard==0 && (y_cnt>ty || (y_cnt==ty && x_cnt>=tx)).
  - When the condition holds, o_hit=1 and o_desc_start=1 on the next cycle.
  - guard is set for exactly the cycle in which o_hit=1. This prevents a second pop against a stale head while the buffer shifts.
  - Targets with ty>=IMG_H never fire in RUN; they are popped in DRAIN.
- Flag, registered, 1-cycle latency:
  - o_flag=1 the cycle after i_kp_valid in RUN, if occupancy<DEPTH or a hit is issued in that same cycle.
  - Otherwise the keypoint is dropped.
  - i_kp_valid in IDLE or DRAIN is always dropped.
- Occupancy update:
  - flag only: +1.
  - hit only: -1.
  - flag and hit together: unchanged (buffer shifts and inserts).
  - Never exceeds DEPTH or goes below 0. A hit is never issued while empty.
- i_frame_start in RUN or DRAIN: ignored and sets o_seq_err. It clears only on reset.
- Reset mid-frame: immediate return to IDLE and all counters cleared. The buffer is reset by the same i_rst_n.

Optional Feature:
- Macro KEY_BUFFER_CTRL_STATS_EN.
- Defined:
  - o_drop_cnt is a 16-bit saturating count of dropped keypoints, cleared on reset only.
  - o_peak_occ is the running max of o_count, cleared on frame start.
- Undefined: both outputs tied to 0 and no counter logic is instantiated.

Test Plan:
All scenarios use params IMG_W=16, IMG_H=16, DELAY_ROWS=2, DELAY_COLS=3, DEPTH=4.
- Basic pop: keypoint (5,4) inserted, head=(5,4), stream pixels -> o_flag one cycle after i_kp_valid; o_hit+o_desc_start the cycle after pixel (8,6) is valid; o_count 1->0.
- Adjacent targets: keypoints (5,4) and (6,4), continuous pixels -> two hits, never on consecutive cycles; the second fires on pixel (9,6) or the first valid pixel after the guard; o_count ends 0.
- Full/drop: 5 keypoints with no hits -> 4 flags, 5th dropped, o_full=1, o_drop_cnt=1 (STATS_EN).
- Full with simultaneous hit: o_count=4, hit cycle coincides with insert -> o_flag=1 and o_hit=1 in the same cycle, o_count stays 4, no drop.
- Drain: 3 keypoints at y=15 -> no RUN hits; after pixel (15,15), 3 hits with o_desc_start=0, then o_frame_done pulse, state IDLE.
- Sequencing/reset: i_frame_start mid-RUN -> o_seq_err=1, counters continue; async reset mid-frame -> all outputs 0 within the same cycle.
